addsub_job_issuer: RTL

//  Initiator for the multicycle add/sub unit (controlUnitFSM + addSub). Accepts operand jobs

---
 rtl/addsub_pkg.sv | 7 +
 rtl/addsub_ref_model.sv | 15 +
 rtl/addsub_job_issuer.sv | 117 +++++++++++
 3 files changed

// File: rtl/addsub_pkg.sv
// addsub_pkg: shared state encoding, mode codes and default width for the add/sub job issuer
package addsub_pkg;
  localparam int WIDTH_DEF = 8;
  localparam logic MODE_APBPCMD = 1'b0;
  localparam logic MODE_AMBPCPD = 1'b1;
  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_CAPTURE, S_TOUT, S_CLEAR} state_t;
endpackage

// File: rtl/addsub_ref_model.sv
// addsub_ref_model: expected result of the add/sub unit, wrapping modulo 2^WIDTH
module addsub_ref_model
  import addsub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] y
);
  always_comb y = (mode == MODE_AMBPCPD) ? a - b + c + d : a + b + c - d;
endmodule

// File: rtl/addsub_job_issuer.sv
// addsub_job_issuer: feeds host jobs to the multicycle add/sub unit and returns checked results
module addsub_job_issuer
  import addsub_pkg::*;
#(
  parameter int WIDTH        = WIDTH_DEF,
  parameter int START_CYCLES = 2,
  parameter int TIMEOUT      = 16,
  parameter int CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic             job_mode,
  input  logic [WIDTH-1:0] job_a,
  input  logic [WIDTH-1:0] job_b,
  input  logic [WIDTH-1:0] job_c,
  input  logic [WIDTH-1:0] job_d,
  output logic             start,
  output logic             mode,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] op_c,
  output logic [WIDTH-1:0] op_d,
  output logic             unit_reset,
  input  logic             done,
  input  logic [WIDTH-1:0] result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_mismatch,
  output logic             res_timeout,
  output logic             busy,
  output logic [CNT_W-1:0] job_count,
  output logic [CNT_W-1:0] err_count
);
  localparam int SC_W = START_CYCLES > 1 ? $clog2(START_CYCLES) : 1;
  localparam int TM_W = $clog2(TIMEOUT + 1);
  state_t state, state_n;
  logic [SC_W-1:0] scnt;
  logic [TM_W-1:0] timer;
  logic done_seen, load, mis, err_inc;
  logic [WIDTH-1:0] expected;
  addsub_ref_model #(.WIDTH(WIDTH)) u_ref (
    .mode(mode), .a(op_a), .b(op_b), .c(op_c), .d(op_d), .y(expected)
  );
  assign job_ready  = state == S_IDLE;
  assign start      = state == S_START;
  assign busy       = state != S_IDLE;
  assign unit_reset = reset || state == S_CLEAR;
  // a full result register only blocks a load when the host is not draining it this cycle
  assign load    = (state == S_CAPTURE || state == S_TOUT) && (!res_valid || res_ready);
  assign mis     = result != expected;
  assign err_inc = state == S_TOUT || mis;
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:    state_n = job_valid ? S_START : S_IDLE;
      S_START:   state_n = scnt == '0 ? S_WAIT : S_START;
      S_WAIT:    state_n = (done || done_seen) ? S_CAPTURE :
                           timer == TM_W'(TIMEOUT) ? S_TOUT : S_WAIT;
      S_CAPTURE,
      S_TOUT:    state_n = load ? S_CLEAR : state;
      S_CLEAR:   state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      mode         <= 1'b0;
      op_a         <= '0;
      op_b         <= '0;
      op_c         <= '0;
      op_d         <= '0;
      scnt         <= '0;
      timer        <= '0;
      done_seen    <= 1'b0;
      res_valid    <= 1'b0;
      res_data     <= '0;
      res_mismatch <= 1'b0;
      res_timeout  <= 1'b0;
      job_count    <= '0;
      err_count    <= '0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && job_valid) begin
        mode <= job_mode;
        op_a <= job_a;
        op_b <= job_b;
        op_c <= job_c;
        op_d <= job_d;
        scnt <= SC_W'(START_CYCLES - 1);
      end
      if (state == S_START) begin
        scnt      <= scnt - 1'b1;
        done_seen <= done_seen || done;
        if (scnt == '0) timer <= TM_W'(1);
      end
      if (state == S_WAIT) timer <= timer + 1'b1;
      if (state == S_CLEAR) begin
        done_seen <= 1'b0;
        timer     <= '0;
      end
      if (load) begin
        res_valid    <= 1'b1;
        res_data     <= state == S_CAPTURE ? result : '0;
        res_mismatch <= state == S_CAPTURE && mis;
        res_timeout  <= state == S_TOUT;
        job_count    <= &job_count ? job_count : job_count + 1'b1;
        err_count    <= (err_inc && !(&err_count)) ? err_count + 1'b1 : err_count;
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end
endmodule
